// File: rtl/ic_arb_pkg.sv
// Shared arbiter definitions: FSM state encoding and one-hot to index conversion.
package ic_arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  localparam int ARB_MAX_MSTR = 8;

  function automatic logic [2:0] onehot_to_idx(input logic [ARB_MAX_MSTR-1:0] oh);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < ARB_MAX_MSTR; i++) begin
      if (oh[i]) begin
        idx = idx | 3'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/ic_rr_pick.sv
// Rotating-priority picker: first set request at or above ptr_i, wrapping at N-1.
module ic_rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [N-1:0] gnt_o
);

  localparam logic [W:0] NUM_C = (W+1)'(N);

  always_comb begin
    logic       found;
    logic [W:0] pos;
    gnt_o = '0;
    found = 1'b0;
    pos   = '0;
    for (int i = 0; i < N; i++) begin
      pos = {1'b0, ptr_i} + (W+1)'(i);
      if (pos >= NUM_C) begin
        pos = pos - NUM_C;
      end else begin
        pos = pos;
      end
      if (!found && req_i[pos[W-1:0]]) begin
        gnt_o[pos[W-1:0]] = 1'b1;
        found             = 1'b1;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/ic_slave_aw_arb.sv
// Per-slave AW arbiter with outstanding-write cap.
// IC_AW_ARB_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module ic_slave_aw_arb
  import ic_arb_pkg::*;
#(
  parameter int MSTR_NUM        = 4,
  parameter int MSTR_BITS       = 2,
  parameter int MAX_OUTSTANDING = 8,
  parameter int CNT_BITS        = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [MSTR_NUM-1:0]  M_AWREQ,
  output logic [MSTR_NUM-1:0]  M_AWREADY,
  output logic                 S_AWVALID,
  input  logic                 S_AWREADY,
  input  logic                 S_WVALID,
  input  logic                 S_WREADY,
  input  logic                 S_WLAST,
  output logic [MSTR_NUM-1:0]  AW_GRANT,
  output logic [MSTR_BITS-1:0] AWMSTR,
  output logic [CNT_BITS-1:0]  OUTSTANDING,
  output logic                 ARB_FULL
);

  localparam logic [CNT_BITS-1:0]  MAX_C  = CNT_BITS'(MAX_OUTSTANDING);
  localparam logic [MSTR_BITS-1:0] LAST_C = MSTR_BITS'(MSTR_NUM - 1);

  arb_state_e            state_q;
  logic [MSTR_NUM-1:0]   grant_q;
  logic [MSTR_BITS-1:0]  awmstr_q;
  logic                  awvalid_q;
  logic [CNT_BITS-1:0]   cnt_q;
  logic [CNT_BITS-1:0]   cnt_d;
  logic                  full_q;
  logic [MSTR_NUM-1:0]   win_s;
  logic [MSTR_BITS-1:0]  pick_ptr_s;
  logic                  aw_hs_s;
  logic                  retire_s;

`ifdef IC_AW_ARB_FIXED_PRIO_EN
  assign pick_ptr_s = '0;
`else
  logic [MSTR_BITS-1:0] ptr_q;

  // Pointer moves just past the master whose AW handshake completed.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else if (aw_hs_s) begin
      ptr_q <= (awmstr_q == LAST_C) ? '0 : awmstr_q + MSTR_BITS'(1);
    end else begin
      ptr_q <= ptr_q;
    end
  end

  assign pick_ptr_s = ptr_q;
`endif

  ic_rr_pick #(
    .N (MSTR_NUM),
    .W (MSTR_BITS)
  ) u_pick (
    .req_i (M_AWREQ),
    .ptr_i (pick_ptr_s),
    .gnt_o (win_s)
  );

  assign aw_hs_s  = (state_q == ARB_GRANT) && S_AWREADY;
  assign retire_s = S_WVALID && S_WREADY && S_WLAST;

  // Outstanding count; a new AW never arrives at the cap because full blocks grants.
  always_comb begin
    cnt_d = cnt_q;
    if (aw_hs_s && !retire_s) begin
      cnt_d = cnt_q + CNT_BITS'(1);
    end else if (!aw_hs_s && retire_s && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_BITS'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Grant FSM with registered grant, index and AWVALID.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ARB_IDLE;
      grant_q   <= '0;
      awmstr_q  <= '0;
      awvalid_q <= 1'b0;
      cnt_q     <= '0;
      full_q    <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      full_q <= (cnt_d == MAX_C);
      case (state_q)
        ARB_IDLE: begin
          if ((|M_AWREQ) && !full_q) begin
            state_q   <= ARB_GRANT;
            grant_q   <= win_s;
            awmstr_q  <= MSTR_BITS'(onehot_to_idx(ARB_MAX_MSTR'(win_s)));
            awvalid_q <= 1'b1;
          end else begin
            state_q   <= ARB_IDLE;
            grant_q   <= '0;
            awvalid_q <= 1'b0;
          end
        end
        ARB_GRANT: begin
          if (S_AWREADY) begin
            state_q   <= ARB_IDLE;
            grant_q   <= '0;
            awvalid_q <= 1'b0;
          end else begin
            state_q   <= ARB_GRANT;
            awvalid_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= ARB_IDLE;
          grant_q   <= '0;
          awvalid_q <= 1'b0;
        end
      endcase
    end
  end

  assign M_AWREADY   = grant_q & {MSTR_NUM{S_AWREADY}};
  assign S_AWVALID   = awvalid_q;
  assign AW_GRANT    = grant_q;
  assign AWMSTR      = awmstr_q;
  assign OUTSTANDING = cnt_q;
  assign ARB_FULL    = full_q;

endmodule

// File: tb/tb_ic_slave_aw_arb.sv
// Directed bench for ic_slave_aw_arb with an expected-winner scoreboard queue.
module tb_ic_slave_aw_arb;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] M_AWREQ;
  logic [3:0] M_AWREADY;
  logic       S_AWVALID;
  logic       S_AWREADY;
  logic       S_WVALID;
  logic       S_WREADY;
  logic       S_WLAST;
  logic [3:0] AW_GRANT;
  logic [1:0] AWMSTR;
  logic [3:0] OUTSTANDING;
  logic       ARB_FULL;

  int n_pass  = 0;
  int n_total = 0;
  logic [1:0] exp_q[$];

  ic_slave_aw_arb #(
    .MSTR_NUM        (4),
    .MSTR_BITS       (2),
    .MAX_OUTSTANDING (2),
    .CNT_BITS        (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .M_AWREQ     (M_AWREQ),
    .M_AWREADY   (M_AWREADY),
    .S_AWVALID   (S_AWVALID),
    .S_AWREADY   (S_AWREADY),
    .S_WVALID    (S_WVALID),
    .S_WREADY    (S_WREADY),
    .S_WLAST     (S_WLAST),
    .AW_GRANT    (AW_GRANT),
    .AWMSTR      (AWMSTR),
    .OUTSTANDING (OUTSTANDING),
    .ARB_FULL    (ARB_FULL)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_grant(input string tag);
    logic [1:0] e;
    if (exp_q.size() == 0) begin
      n_total++;
      $error("FAIL %s: scoreboard empty at grant, got AWMSTR %0d", tag, AWMSTR);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_valid"}, 32'(S_AWVALID), 32'd1);
      chk({tag, "_awmstr"}, 32'(AWMSTR), 32'(e));
      chk({tag, "_grant"}, 32'(AW_GRANT), 32'd1 << e);
    end
  endtask

  task automatic set_retire(input logic v);
    S_WVALID = v;
    S_WREADY = v;
    S_WLAST  = v;
  endtask

  initial begin
    reset     = 1'b1;
    M_AWREQ   = 4'b0000;
    S_AWREADY = 1'b0;
    set_retire(1'b0);
    tick();
    tick();
    reset = 1'b0;
    chk("rst_grant", 32'(AW_GRANT), 32'd0);
    chk("rst_awmstr", 32'(AWMSTR), 32'd0);
    chk("rst_valid", 32'(S_AWVALID), 32'd0);
    chk("rst_ready", 32'(M_AWREADY), 32'd0);
    chk("rst_outst", 32'(OUTSTANDING), 32'd0);
    chk("rst_full", 32'(ARB_FULL), 32'd0);

    // Single request from master 1
    M_AWREQ   = 4'b0010;
    S_AWREADY = 1'b1;
    exp_q.push_back(2'd1);
    tick();
    chk_grant("single");
    chk("single_ready", 32'(M_AWREADY), 32'h2);
    M_AWREQ = 4'b0000;
    tick();
    chk("single_valid_drop", 32'(S_AWVALID), 32'd0);
    chk("single_outst", 32'(OUTSTANDING), 32'd1);
    set_retire(1'b1);
    tick();
    chk("single_retire", 32'(OUTSTANDING), 32'd0);

    // Contention, retire held high so the counter never blocks
    M_AWREQ = 4'b1111;
`ifdef IC_AW_ARB_FIXED_PRIO_EN
    for (int i = 0; i < 5; i++) exp_q.push_back(2'd0);
`else
    exp_q.push_back(2'd2);
    exp_q.push_back(2'd3);
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd2);
`endif
    for (int g = 0; g < 5; g++) begin
      tick();
      chk_grant("rr");
      tick();
      chk("rr_idle", 32'(S_AWVALID), 32'd0);
    end
    M_AWREQ = 4'b0000;
    set_retire(1'b0);
    chk("rr_outst", 32'(OUTSTANDING), 32'd0);

    // Slave stall on master 2 while master 0 also requests
    M_AWREQ   = 4'b0100;
    S_AWREADY = 1'b0;
    exp_q.push_back(2'd2);
    tick();
    chk_grant("stall");
    M_AWREQ = 4'b0101;
    for (int c = 0; c < 5; c++) begin
      chk("stall_valid", 32'(S_AWVALID), 32'd1);
      chk("stall_grant", 32'(AW_GRANT), 32'h4);
      chk("stall_ready", 32'(M_AWREADY), 32'h0);
      tick();
    end
    S_AWREADY = 1'b1;
    #1;
    chk("stall_ready_hs", 32'(M_AWREADY), 32'h4);
    tick();
    chk("stall_outst", 32'(OUTSTANDING), 32'd1);
    chk("stall_valid_drop", 32'(S_AWVALID), 32'd0);

    // Fill to the cap of 2 and confirm grants are blocked
    M_AWREQ = 4'b0001;
    exp_q.push_back(2'd0);
    tick();
    chk_grant("fill");
    M_AWREQ = 4'b1000;
    exp_q.push_back(2'd3);
    tick();
    chk("full_outst", 32'(OUTSTANDING), 32'd2);
    chk("full_flag", 32'(ARB_FULL), 32'd1);
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("full_blocked_valid", 32'(S_AWVALID), 32'd0);
      chk("full_blocked_grant", 32'(AW_GRANT), 32'h0);
    end
    set_retire(1'b1);
    tick();
    set_retire(1'b0);
    chk("unfull_outst", 32'(OUTSTANDING), 32'd1);
    chk("unfull_flag", 32'(ARB_FULL), 32'd0);
    chk("unfull_nogrant_yet", 32'(S_AWVALID), 32'd0);
    tick();
    chk_grant("unfull");
    M_AWREQ = 4'b0000;
    tick();
    chk("refull_outst", 32'(OUTSTANDING), 32'd2);
    chk("refull_flag", 32'(ARB_FULL), 32'd1);

    // Handshake and retire together, then the zero floor
    set_retire(1'b1);
    tick();
    set_retire(1'b0);
    chk("drain_outst", 32'(OUTSTANDING), 32'd1);
    M_AWREQ = 4'b0010;
    exp_q.push_back(2'd1);
    tick();
    chk_grant("simul");
    M_AWREQ = 4'b0000;
    set_retire(1'b1);
    tick();
    chk("simul_outst", 32'(OUTSTANDING), 32'd1);
    tick();
    chk("retire_to_zero", 32'(OUTSTANDING), 32'd0);
    tick();
    chk("retire_floor", 32'(OUTSTANDING), 32'd0);
    set_retire(1'b0);

    // Reset in the middle of a grant
    S_AWREADY = 1'b0;
    M_AWREQ   = 4'b1010;
`ifdef IC_AW_ARB_FIXED_PRIO_EN
    exp_q.push_back(2'd1);
`else
    exp_q.push_back(2'd3);
`endif
    tick();
    chk_grant("pre_rst");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_valid", 32'(S_AWVALID), 32'd0);
    chk("midrst_grant", 32'(AW_GRANT), 32'h0);
    chk("midrst_awmstr", 32'(AWMSTR), 32'd0);
    chk("midrst_outst", 32'(OUTSTANDING), 32'd0);
    chk("midrst_full", 32'(ARB_FULL), 32'd0);
    S_AWREADY = 1'b1;
    #1;
    chk("midrst_ready", 32'(M_AWREADY), 32'h0);
    exp_q.push_back(2'd1);
    tick();
    chk_grant("post_rst");
    chk("post_rst_ready", 32'(M_AWREADY), 32'h2);
    M_AWREQ = 4'b0000;
    tick();
    chk("post_rst_outst", 32'(OUTSTANDING), 32'd1);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
